// File: rtl/ov7670_axil_pkg.sv
// Shared definitions for the OV7670 AXI4-Lite register file: response codes and FSM states.
package ov7670_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_ADDR_HELD = 2'd1,
        W_DATA_HELD = 2'd2,
        W_RESP      = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

endpackage

// File: rtl/ov7670_axil_regfile_if.sv
// AXI4-Lite slave bus bundle. Every channel transfers on the rising clock edge where
// its VALID and READY are both high; a source keeps VALID and payload stable until then.
interface ov7670_axil_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/ov7670_axil_w1c.sv
// Write-one-to-clear interrupt status register with a registered OR-reduced interrupt line.
module ov7670_axil_w1c #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] src,
    input  logic                  clr_en,
    input  logic [DATA_WIDTH-1:0] clr_mask,
    output logic [DATA_WIDTH-1:0] status,
    output logic                  irq
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            // OR-ing src after the clear lets a live source win over a clear in the same cycle.
            status <= (status & ~(clr_en ? clr_mask : '0)) | src;
            irq    <= |status;
        end
    end

endmodule

// File: rtl/ov7670_axil_regfile.sv
// AXI4-Lite register file with per-register read-only status backing and write pulses.
// Build option OV7670_AXIL_IRQ_EN adds a W1C interrupt status word at index NUM_REGS.
module ov7670_axil_regfile
    import ov7670_axil_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 8,
    parameter int                  ADDR_WIDTH = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    ov7670_axil_regfile_if.slave           s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            reg_wr_pulse_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i,
    input  logic [DATA_WIDTH-1:0]          irq_src_i,
    output logic                           irq_o,
    output w_state_e                       w_state_dbg,
    output r_state_e                       r_state_dbg
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = ADDR_WIDTH - LSB;
`ifdef OV7670_AXIL_IRQ_EN
    localparam int NUM_DEC = NUM_REGS + 1;
`else
    localparam int NUM_DEC = NUM_REGS;
`endif

    w_state_e              w_state;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]         w_strb_q;

    r_state_e              r_state;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pulse_q;
    logic [DATA_WIDTH-1:0] irq_status;

    logic                  aw_hs, w_hs, ar_hs, wr_commit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data, wr_mask, rd_data;
    logic [NB-1:0]         wr_strb;
    logic [1:0]            wr_resp, rd_resp;

    // Whichever half arrives last completes the write; the other half comes from the hold registers.
    always_comb begin
        aw_hs     = s_axi.S_AXI_AWVALID && awready_q;
        w_hs      = s_axi.S_AXI_WVALID && wready_q;
        ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
        wr_commit = 1'b0;
        case (w_state)
            W_IDLE:      wr_commit = aw_hs && w_hs;
            W_ADDR_HELD: wr_commit = w_hs;
            W_DATA_HELD: wr_commit = aw_hs;
            default:     wr_commit = 1'b0;
        endcase
        wr_idx  = (w_state == W_ADDR_HELD) ? aw_idx_q : s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
        wr_data = (w_state == W_DATA_HELD) ? w_data_q : s_axi.S_AXI_WDATA;
        wr_strb = (w_state == W_DATA_HELD) ? w_strb_q : s_axi.S_AXI_WSTRB;
        wr_mask = '0;
        for (int b = 0; b < NB; b++) wr_mask[8*b +: 8] = {8{wr_strb[b]}};
        wr_resp = (32'(wr_idx) < 32'(NUM_DEC)) ? RESP_OKAY : RESP_SLVERR;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_idx_q  <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (wr_commit) begin
            w_state   <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_state   <= W_ADDR_HELD;
                        aw_idx_q  <= s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (w_hs) begin
                        w_state   <= W_DATA_HELD;
                        w_data_q  <= s_axi.S_AXI_WDATA;
                        w_strb_q  <= s_axi.S_AXI_WSTRB;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        w_state   <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pulse_q[i] <= 1'b0;
                if (wr_commit && wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
                    regs_q[i]  <= (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
                    pulse_q[i] <= 1'b1;
                end
            end
        end
    end

    // Registers are sampled before this edge's write lands, so a colliding read sees the old value.
    always_comb begin
        rd_idx  = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_resp = RESP_OKAY;
                rd_data = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
`ifdef OV7670_AXIL_IRQ_EN
        if (rd_idx == IDX_W'(NUM_REGS)) begin
            rd_resp = RESP_OKAY;
            rd_data = irq_status;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state   <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_state   <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifdef OV7670_AXIL_IRQ_EN
    ov7670_axil_w1c #(.DATA_WIDTH(DATA_WIDTH)) u_w1c (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .src      (irq_src_i),
        .clr_en   (wr_commit && wr_idx == IDX_W'(NUM_REGS)),
        .clr_mask (wr_data & wr_mask),
        .status   (irq_status),
        .irq      (irq_o)
    );
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0],
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};
`else
    assign irq_status = '0;
    assign irq_o      = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0],
                           s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, irq_src_i, irq_status};
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign reg_wr_pulse_o       = pulse_q;
    assign s_axi.S_AXI_AWREADY  = awready_q;
    assign s_axi.S_AXI_WREADY   = wready_q;
    assign s_axi.S_AXI_BVALID   = bvalid_q;
    assign s_axi.S_AXI_BRESP    = bresp_q;
    assign s_axi.S_AXI_ARREADY  = arready_q;
    assign s_axi.S_AXI_RVALID   = rvalid_q;
    assign s_axi.S_AXI_RDATA    = rdata_q;
    assign s_axi.S_AXI_RRESP    = rresp_q;
    assign w_state_dbg          = w_state;
    assign r_state_dbg          = r_state;

endmodule
